// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM of the multi-cycle RV32I core. One shared ALU, the register
// file and a single unified instruction/data memory port are sequenced through
// fetch, decode, execute, memory and writeback. Supported opcodes are R-type,
// lw, sw and beq; anything else traps. Every memory wait state is bounded by a
// cycle counter, and running out of cycles traps with a timeout cause.
//
// Parameters
//   MAX_WAIT    cycles allowed in one memory wait state before a timeout trap
//               (1..65535)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset; forces every output to 0
//   opcode      instruction register bits [6:0], valid from DECODE onward
//   zero        ALU zero flag (branch condition)
//   mem_ready   memory completed the current access this cycle
//   mem_req     memory access request
//   mem_we      memory write (only while mem_req=1)
//   adr_src     memory address select: 0=PC, 1=ALUOut
//   ir_write    load instruction register and oldPC
//   pc_write    load PC from the result mux
//   alu_src_a   ALU A select: 00=PC, 01=oldPC, 10=rs1
//   alu_src_b   ALU B select: 00=rs2, 01=immediate, 10=constant 4
//   alu_op      ALUOp: 00=add, 01=sub/compare, 10=decode by funct
//   result_src  result mux: 00=ALUOut, 01=memory data reg, 10=live ALU result
//   reg_write   register file write enable
//   retire      one-cycle pulse when an instruction completes
//   trap        sticky fault flag
//   trap_cause  00=none, 01=illegal opcode, 10=memory timeout
//   state       current state encoding, for debug
// -----------------------------------------------------------------------------
module multicycle_control #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       reg_write,
   output logic       retire,
   output logic       trap,
   output logic [1:0] trap_cause,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      ALUWB    = 4'd7,
      BEQ      = 4'd8,
      TRAP     = 4'd15
   } state_t;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   // Last counter value that may still be spent waiting; one more idle cycle
   // after it would exceed MAX_WAIT.
   localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

   state_t      state_q;
   state_t      state_d;
   logic [1:0]  cause_q;
   logic [1:0]  cause_d;
   logic [15:0] wait_cnt;
   logic        waiting;
   logic        timeout;

   // States that hold the memory port and wait for mem_ready.
   assign waiting = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
   // A ready in the final allowed cycle still completes the access.
   assign timeout = waiting && !mem_ready && (wait_cnt == WAIT_LAST);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of process order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= FETCH;
         cause_q  <= CAUSE_NONE;
         wait_cnt <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         // Any state change clears the counter, so each wait state is entered
         // with a fresh budget.
         if (state_d != state_q) begin
            wait_cnt <= '0;
         end else if (waiting && !mem_ready) begin
            wait_cnt <= wait_cnt + 16'd1;
         end
      end
   end

   // Next-state logic. trap_cause is only written on the transition into TRAP
   // and then held, since TRAP never exits without reset.
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         FETCH: begin
            if (mem_ready) begin
               state_d = DECODE;
            end else if (timeout) begin
               state_d = TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECR;
               OP_BEQ:       state_d = BEQ;
               default: begin
                  state_d = TRAP;
                  cause_d = CAUSE_ILLEGAL;
               end
            endcase
         end
         MEMADR: state_d = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD: begin
            if (mem_ready) begin
               state_d = MEMWB;
            end else if (timeout) begin
               state_d = TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         MEMWB: state_d = FETCH;
         MEMWRITE: begin
            if (mem_ready) begin
               state_d = FETCH;
            end else if (timeout) begin
               state_d = TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         EXECR: state_d = ALUWB;
         ALUWB: state_d = FETCH;
         BEQ:   state_d = FETCH;
         TRAP:  state_d = TRAP;
         // Unused encodings can only come from an upset; park them in TRAP.
         default: begin
            state_d = TRAP;
            cause_d = CAUSE_ILLEGAL;
         end
      endcase
   end

   // Output decode: Moore by state, except ir_write/pc_write (and the store
   // retire) which qualify on mem_ready or zero. Reset overrides everything so
   // an aborted store cannot keep mem_we up after the asynchronous assertion.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      reg_write  = 1'b0;
      retire     = 1'b0;
      trap       = 1'b0;
      trap_cause = cause_q;
      state      = state_q;
      case (state_q)
         FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         DECODE: begin
            // oldPC + imm lands in ALUOut as the branch target.
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            retire     = 1'b1;
         end
         MEMWRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
            retire  = mem_ready;
         end
         EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
         end
         BEQ: begin
            // Compare rs1-rs2; ALUOut still holds the target from DECODE.
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            pc_write  = zero;
            retire    = 1'b1;
         end
         TRAP: trap = 1'b1;
         default: ;
      endcase
      if (reset) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         adr_src    = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         alu_src_a  = 2'b00;
         alu_src_b  = 2'b00;
         alu_op     = 2'b00;
         result_src = 2'b00;
         reg_write  = 1'b0;
         retire     = 1'b0;
         trap       = 1'b0;
         trap_cause = 2'b00;
         state      = 4'd0;
      end
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I core. It sequences one shared ALU, the register file, and one unified instruction/data memory port through fetch, decode, execute, memory and writeback.
- It produces the 2-bit ALUOp consumed by the core's ALU control decoder (00=add, 01=sub/compare, 10=decode by funct), plus the mux selects and write enables for the datapath.
- Supported opcodes: R-type 0110011, lw 0000011, sw 0100011, beq 1100011. Any other opcode traps.

Parameters:
- MAX_WAIT, 255: maximum number of cycles spent in one memory wait state before a timeout trap; legal range 1..65535.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  7  instruction register bits [6:0], valid from DECODE onward.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current access this cycle.
- mem_req  output  1  memory access request.
- mem_we  output  1  memory write (only while mem_req=1).
- adr_src  output  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  output  1  load instruction register and oldPC.
- pc_write  output  1  load PC from the result mux.
- alu_src_a  output  2  ALU A select: 00=PC, 01=oldPC, 10=rs1 register.
- alu_src_b  output  2  ALU B select: 00=rs2 register, 01=immediate, 10=constant 4.
- alu_op  output  2  ALUOp to the ALU control decoder.
- result_src  output  2  result mux select: 00=ALUOut, 01=memory data register, 10=live ALU result.
- reg_write  output  1  register file write enable.
- retire  output  1  one-cycle pulse when an instruction completes.
- trap  output  1  sticky fault flag.
- trap_cause  output  2  00=none, 01=illegal opcode, 10=memory timeout.
- state  output  4  current state encoding, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, BEQ=8, TRAP=15.
- Reset:
  - While reset=1, state=FETCH, the wait counter=0, trap=0 and trap_cause=00.
  - Every output except state is forced to 0 while reset is asserted, regardless of state; state reads 0.
  - After reset release, the first clock edge begins in FETCH.
  - Reset asserted mid-instruction aborts it immediately; no partial write is issued after the asynchronous assertion.
- Outputs are Moore by state, except pc_write and ir_write, which are gated by mem_ready or zero as noted below. Any signal not listed for a state is 0.
- FETCH:
  - Drives mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=01, alu_op=00 (the branch target is latched into ALUOut).
  - Next state by opcode: lw/sw -> MEMADR, R-type -> EXECR, beq -> BEQ, other -> TRAP with cause 01.
- MEMADR:
  - Drives alu_src_a=10, alu_src_b=01, alu_op=00.
  - Next state: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD:
  - Drives mem_req=1, adr_src=1.
  - Goes to MEMWB on mem_ready.
- MEMWB:
  - Drives result_src=01, reg_write=1, retire=1.
  - Goes to FETCH.
- MEMWRITE:
  - Drives mem_req=1, mem_we=1, adr_src=1.
  - On mem_ready: retire=1 in that same cycle, then go to FETCH.
- EXECR:
  - Drives alu_src_a=10, alu_src_b=00, alu_op=10.
  - Goes to ALUWB.
- ALUWB:
  - Drives result_src=00, reg_write=1, retire=1.
  - Goes to FETCH.
- BEQ:
  - Drives alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write=zero; retire=1.
  - Goes to FETCH.
- TRAP:
  - All enables are 0 and trap=1.
  - The state is absorbing; only reset exits it.
- Wait counter (16-bit):
  - Clears on entry to each of FETCH, MEMREAD and MEMWRITE.
  - Increments every cycle spent in one of those states with mem_ready=0.
  - When the counter equals MAX_WAIT-1 and mem_ready=0, the next state is TRAP with cause 10.
  - If mem_ready=1 in that same cycle, the access completes normally; the ready signal wins.
- Latency with mem_ready tied to 1: R-type 4 cycles, lw 5, sw 4, beq 3.
- trap_cause latches on TRAP entry and holds until reset.

Test Plan:
- R-type with mem_ready=1 -> states 0,1,6,7. alu_op=10 in EXECR; reg_write=1 and retire=1 only in ALUWB; the next FETCH follows on cycle 5.
- lw with mem_ready held 0 for 3 cycles in MEMREAD -> mem_req=1, adr_src=1 for 4 cycles; MEMWB asserts result_src=01 and reg_write=1 exactly once.
- beq twice, with zero=1 then zero=0 -> in BEQ, pc_write=1 and 0 respectively; alu_op=01; retire=1 both times; 3 cycles each.
- Opcode 1111111 -> DECODE goes to TRAP; trap=1, trap_cause=01, state=15; it stays there for 100 cycles with all enables 0.
- MAX_WAIT=4 and mem_ready never asserted in FETCH -> after 4 cycles in FETCH the next state is TRAP with cause 10. Repeat with mem_ready=1 on the 4th cycle -> goes to DECODE, no trap.
- Assert reset during MEMWRITE -> mem_we drops asynchronously that same cycle; after release the state is FETCH, trap=0, and no retire pulse occurs.
